if_id_reg: RTL and testbench
============================

Name: if_id_reg

Overview:
- Fetch-to-decode pipeline register that sits directly downstream of the PC/fetch unit.
- Captures the fetched PC and instruction word, detects fetch-address exceptions, and tags delay-slot instructions.
- Implements stall (hold), flush (bubble) and exception-request (bubble at handler PC) for the D stage.
- Keeps a saturating stall-cycle counter for debug and performance visibility.

Parameters:
- RESET_PC, 32'h0000_3000, PC_D value after reset.
- HANDLER_PC, 32'h0000_4180, PC_D value loaded on exception request.
- IM_LO, 32'h0000_3000, lowest legal fetch address.
- IM_HI, 32'h0000_6FFC, highest legal fetch address (inclusive).
- CNT_W, 16, width of the stall counter.

Ports:
- Clk, input, 1, system clock; all state updates on posedge.
- Rst, input, 1, synchronous active-high reset.
- En, input, 1, 1 = capture new F-stage contents; 0 = stall (hold).
- Flush, input, 1, insert a bubble (eret / squash); PC is preserved.
- Req, input, 1, exception/interrupt request from CP0; all stages flush.
- PC_F, input, 32, PC of the instruction in F, from the PC register.
- Instr_F, input, 32, instruction word read from instruction memory at PC_F.
- BD_F, input, 1, 1 = the F instruction is in a branch/jump delay slot.
- PC_D, output, 32, registered PC for D.
- Instr_D, output, 32, registered instruction for D (0 = nop).
- ExcCode_D, output, 5, fetch exception code (0 = none, 4 = AdEL).
- BD_D, output, 1, registered delay-slot flag.
- Valid_D, output, 1, 1 = D holds a real fetched instruction; 0 = bubble.
- StallCnt, output, CNT_W, count of stall cycles since reset.

Behaviour:
- All registers update only on posedge Clk.
- Outputs are driven directly from registers; there is no combinational path from input to output.
- Update priority, evaluated each cycle: Rst > Req > Flush > !En (stall) > capture.
- Rst:
  - PC_D = RESET_PC; Instr_D = 0; ExcCode_D = 0; BD_D = 0; Valid_D = 0; StallCnt = 0.
  - Rst asserted mid-operation discards any pending stall or exception.
- Req:
  - PC_D = HANDLER_PC; Instr_D = 0; ExcCode_D = 0; BD_D = 0; Valid_D = 0.
  - Req wins over En = 0 and over Flush in the same cycle.
- Flush (with Req = 0):
  - PC_D = PC_F; Instr_D = 0; ExcCode_D = 0; BD_D = 0; Valid_D = 0.
  - Flush overrides a stall in the same cycle.
- Stall (En = 0, no Rst/Req/Flush):
  - All D outputs hold their values.
  - StallCnt increments by 1 and saturates at all-ones; it never wraps.
- Capture (En = 1):
  - PC_D = PC_F; BD_D = BD_F; Valid_D = 1.
  - Fetch-fault check: PC_F[1:0] != 0, or PC_F < IM_LO, or PC_F > IM_HI (unsigned 32-bit compares).
  - On fault: ExcCode_D = 4 and Instr_D = 0 (nop substituted; Instr_F is ignored).
  - Otherwise: ExcCode_D = 0 and Instr_D = Instr_F.
  - Boundary cases: PC_F = IM_HI is legal; IM_HI+4 faults; IM_LO-4 faults; 32'hFFFF_FFFC faults.
- StallCnt changes only in stall cycles and on Rst.
- Latency is one cycle from F inputs to D outputs.

Decomposition:
- Shared package holds:
  - exception code constants: EXC_NONE = 0, EXC_ADEL = 4, EXC_ADES = 5, EXC_RI = 10, EXC_OV = 12, EXC_INT = 0;
  - address constants: RESET_PC, HANDLER_PC, IM_LO, IM_HI;
  - NOP = 32'h0. These are reused by the later stage registers and CP0.
- One natural sub-module, fetch_addr_chk: combinational, PC in, fault and ExcCode out. The D/E stage registers reuse it for the AdEL/AdES range checks.

Test Plan:
- Reset: hold Rst for 2 cycles, then release with En = 1, PC_F = 0x3000, Instr_F = 0x3C01_1234 → during reset PC_D = 0x3000, Valid_D = 0; on the next edge Instr_D = 0x3C01_1234, Valid_D = 1, ExcCode_D = 0.
- Stall and counter: capture PC 0x3004, then En = 0 for 3 cycles with PC_F changing → PC_D stays 0x3004 and StallCnt = 3. With CNT_W forced to 2 and 5 stall cycles → StallCnt saturates at 3.
- Fetch faults:
  - PC_F = 0x3002 → ExcCode_D = 4, Instr_D = 0, Valid_D = 1.
  - PC_F = 0x6FFC → ExcCode_D = 0.
  - PC_F = 0x7000 → ExcCode_D = 4.
  - PC_F = 0x2FFC → ExcCode_D = 4.
- Priorities:
  - Req = 1, Flush = 1, En = 0 in the same cycle → PC_D = 0x4180, Valid_D = 0, StallCnt unchanged.
  - Flush = 1 with En = 0 and PC_F = 0x3010 → PC_D = 0x3010, Instr_D = 0.
- Delay slot: capture with BD_F = 1 at PC 0x3008 → BD_D = 1. A following Flush → BD_D = 0.

Source files
------------

// File: rtl/if_id_reg_pkg.sv
// Shared pipeline constants: exception codes, memory map and the nop encoding.
// Reused by the stage registers and CP0.
package if_id_reg_pkg;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] IM_LO      = 32'h0000_3000;
  localparam logic [31:0] IM_HI      = 32'h0000_6FFC;

  localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg_fetch_addr_chk.sv
// Combinational fetch-address check: misaligned or outside [LO, HI] raises AdEL.
// The later stage registers reuse it for their own address range checks.
module if_id_reg_fetch_addr_chk
  import if_id_reg_pkg::*;
#(
  parameter logic [31:0] LO = IM_LO,
  parameter logic [31:0] HI = IM_HI
) (
  input  logic [31:0] pc_i,
  output logic        fault_o,
  output logic [4:0]  exc_code_o
);

  always_comb begin
    fault_o    = (pc_i[1:0] != 2'b00) || (pc_i < LO) || (pc_i > HI);
    exc_code_o = fault_o ? EXC_ADEL : EXC_NONE;
  end

endmodule

// File: rtl/if_id_reg.sv
// Fetch-to-decode pipeline register with stall, flush, exception redirect,
// fetch-address fault tagging and a saturating stall-cycle counter.
module if_id_reg
  import if_id_reg_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = if_id_reg_pkg::RESET_PC,
  parameter logic [31:0] HANDLER_PC = if_id_reg_pkg::HANDLER_PC,
  parameter logic [31:0] IM_LO      = if_id_reg_pkg::IM_LO,
  parameter logic [31:0] IM_HI      = if_id_reg_pkg::IM_HI,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic             Flush,
  input  logic             Req,
  input  logic [31:0]      PC_F,
  input  logic [31:0]      Instr_F,
  input  logic             BD_F,
  output logic [31:0]      PC_D,
  output logic [31:0]      Instr_D,
  output logic [4:0]       ExcCode_D,
  output logic             BD_D,
  output logic             Valid_D,
  output logic [CNT_W-1:0] StallCnt
);

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [4:0]       exc_q, exc_d;
  logic             bd_q, bd_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             fetch_fault;
  logic [4:0]       fetch_exc;

  if_id_reg_fetch_addr_chk #(
    .LO (IM_LO),
    .HI (IM_HI)
  ) u_fetch_addr_chk (
    .pc_i       (PC_F),
    .fault_o    (fetch_fault),
    .exc_code_o (fetch_exc)
  );

  // Priority: Req > Flush > stall > capture; Rst is applied in the flop block.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    exc_d   = exc_q;
    bd_d    = bd_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (Req) begin
      pc_d    = HANDLER_PC;
      instr_d = NOP;
      exc_d   = EXC_NONE;
      bd_d    = 1'b0;
      valid_d = 1'b0;
    end else if (Flush) begin
      pc_d    = PC_F;
      instr_d = NOP;
      exc_d   = EXC_NONE;
      bd_d    = 1'b0;
      valid_d = 1'b0;
    end else if (!En) begin
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
    end else begin
      pc_d    = PC_F;
      instr_d = fetch_fault ? NOP : Instr_F;
      exc_d   = fetch_exc;
      bd_d    = BD_F;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      exc_q   <= EXC_NONE;
      bd_q    <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      exc_q   <= exc_d;
      bd_q    <= bd_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PC_D      = pc_q;
  assign Instr_D   = instr_q;
  assign ExcCode_D = exc_q;
  assign BD_D      = bd_q;
  assign Valid_D   = valid_q;
  assign StallCnt  = cnt_q;

endmodule

// File: tb/tb_if_id_reg.sv
// Directed-vector bench for if_id_reg; a second instance with a 2-bit counter
// shares the stimulus to exercise counter saturation.
module tb_if_id_reg;

  logic        Clk = 1'b0;
  logic        Rst, En, Flush, Req, BD_F;
  logic [31:0] PC_F, Instr_F;

  logic [31:0] pc_d, instr_d;
  logic [4:0]  exc_d;
  logic        bd_d, valid_d;
  logic [15:0] cnt_d;

  logic [31:0] pc_d2, instr_d2;
  logic [4:0]  exc_d2;
  logic        bd_d2, valid_d2;
  logic [1:0]  cnt_d2;

  int n_vec = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  if_id_reg u_dut (
    .Clk(Clk), .Rst(Rst), .En(En), .Flush(Flush), .Req(Req),
    .PC_F(PC_F), .Instr_F(Instr_F), .BD_F(BD_F),
    .PC_D(pc_d), .Instr_D(instr_d), .ExcCode_D(exc_d), .BD_D(bd_d),
    .Valid_D(valid_d), .StallCnt(cnt_d)
  );

  if_id_reg #(.CNT_W(2)) u_dut2 (
    .Clk(Clk), .Rst(Rst), .En(En), .Flush(Flush), .Req(Req),
    .PC_F(PC_F), .Instr_F(Instr_F), .BD_F(BD_F),
    .PC_D(pc_d2), .Instr_D(instr_d2), .ExcCode_D(exc_d2), .BD_D(bd_d2),
    .Valid_D(valid_d2), .StallCnt(cnt_d2)
  );

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic en, input logic flush, input logic req,
                       input logic [31:0] pc, input logic [31:0] instr, input logic bd);
    Rst = rst; En = en; Flush = flush; Req = req;
    PC_F = pc; Instr_F = instr; BD_F = bd;
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc;
    logic [31:0] instr_exp;
  } fetch_vec_t;

  fetch_vec_t fv[5];

  initial begin
    fv[0] = '{32'h0000_3002, 32'hDEAD_BEEF, 5'd4, 32'h0};
    fv[1] = '{32'h0000_6FFC, 32'h2222_2222, 5'd0, 32'h2222_2222};
    fv[2] = '{32'h0000_7000, 32'h4444_4444, 5'd4, 32'h0};
    fv[3] = '{32'h0000_2FFC, 32'h5555_5555, 5'd4, 32'h0};
    fv[4] = '{32'hFFFF_FFFC, 32'h6666_6666, 5'd4, 32'h0};

    drive(1, 1, 0, 0, 32'h0000_3000, 32'h3C01_1234, 0);
    step();
    step();
    check_vec("rst_pc",    pc_d,    32'h3000);
    check_vec("rst_valid", {31'b0, valid_d}, 32'h0);
    check_vec("rst_instr", instr_d, 32'h0);
    check_vec("rst_exc",   {27'b0, exc_d}, 32'h0);
    check_vec("rst_bd",    {31'b0, bd_d}, 32'h0);
    check_vec("rst_cnt",   {16'b0, cnt_d}, 32'h0);

    Rst = 0;
    step();
    check_vec("cap0_instr", instr_d, 32'h3C01_1234);
    check_vec("cap0_valid", {31'b0, valid_d}, 32'h1);
    check_vec("cap0_exc",   {27'b0, exc_d}, 32'h0);
    check_vec("cap0_pc",    pc_d, 32'h3000);

    drive(0, 1, 0, 0, 32'h0000_3004, 32'h1111_1111, 0);
    step();
    check_vec("cap1_pc", pc_d, 32'h3004);

    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 32'h0000_3100 + 32'(i * 4), 32'h7777_0000 + 32'(i), 1);
      step();
    end
    check_vec("stall_pc",    pc_d, 32'h3004);
    check_vec("stall_instr", instr_d, 32'h1111_1111);
    check_vec("stall_bd",    {31'b0, bd_d}, 32'h0);
    check_vec("stall_cnt3",  {16'b0, cnt_d}, 32'd3);
    check_vec("stall_cnt3_w2", {30'b0, cnt_d2}, 32'd3);

    step();
    step();
    check_vec("stall_cnt5",  {16'b0, cnt_d}, 32'd5);
    check_vec("sat_cnt_w2",  {30'b0, cnt_d2}, 32'd3);

    foreach (fv[i]) begin
      drive(0, 1, 0, 0, fv[i].pc, fv[i].instr, 0);
      step();
      check_vec($sformatf("fetch%0d_pc", i),    pc_d, fv[i].pc);
      check_vec($sformatf("fetch%0d_exc", i),   {27'b0, exc_d}, {27'b0, fv[i].exc});
      check_vec($sformatf("fetch%0d_instr", i), instr_d, fv[i].instr_exp);
      check_vec($sformatf("fetch%0d_valid", i), {31'b0, valid_d}, 32'h1);
    end
    check_vec("cap_keeps_cnt", {16'b0, cnt_d}, 32'd5);

    drive(0, 0, 1, 1, 32'h0000_3050, 32'h8888_8888, 1);
    step();
    check_vec("req_pc",    pc_d, 32'h4180);
    check_vec("req_valid", {31'b0, valid_d}, 32'h0);
    check_vec("req_instr", instr_d, 32'h0);
    check_vec("req_cnt",   {16'b0, cnt_d}, 32'd5);

    drive(0, 0, 1, 0, 32'h0000_3010, 32'h9999_9999, 1);
    step();
    check_vec("flush_pc",    pc_d, 32'h3010);
    check_vec("flush_instr", instr_d, 32'h0);
    check_vec("flush_valid", {31'b0, valid_d}, 32'h0);
    check_vec("flush_cnt",   {16'b0, cnt_d}, 32'd5);

    drive(0, 1, 0, 0, 32'h0000_3008, 32'h3333_3333, 1);
    step();
    check_vec("bd_set",   {31'b0, bd_d}, 32'h1);
    check_vec("bd_instr", instr_d, 32'h3333_3333);

    drive(0, 1, 1, 0, 32'h0000_300C, 32'hAAAA_AAAA, 1);
    step();
    check_vec("bd_flush", {31'b0, bd_d}, 32'h0);
    check_vec("bd_flush_pc", pc_d, 32'h300C);

    drive(0, 0, 0, 0, 32'h0000_3020, 32'hBBBB_BBBB, 0);
    step();
    check_vec("stall_cnt6", {16'b0, cnt_d}, 32'd6);
    drive(1, 0, 0, 1, 32'h0000_3020, 32'hBBBB_BBBB, 0);
    step();
    check_vec("rst_mid_pc",  pc_d, 32'h3000);
    check_vec("rst_mid_cnt", {16'b0, cnt_d}, 32'h0);
    check_vec("rst_mid_valid", {31'b0, valid_d}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
